disp_arb: RTL and testbench

DISP_ARB -- requirements
Module: disp_arb

---
 rtl/disp_arb_if.sv | 27 ++
 rtl/disp_arb.sv | 123 ++++++++++++
 tb/tb_disp_arb.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/disp_arb_if.sv
// Display arbitration bus.
// Bundles the two requester channels (request + value) and the arbiter
// outputs (per-requester grants, displayed value, owner code).
//   slave  : arbiter side (takes requests/data, drives grants/data_2/modulo)
//   master : requester / display-manager side
interface disp_arb_if #(
  parameter int DATA_W = 16
);
  logic              req_fib;
  logic [DATA_W-1:0] data_fib;
  logic              req_tmr;
  logic [DATA_W-1:0] data_tmr;
  logic              gnt_fib;
  logic              gnt_tmr;
  logic [DATA_W-1:0] data_2;
  logic [1:0]        modulo;

  modport slave (
    input  req_fib, data_fib, req_tmr, data_tmr,
    output gnt_fib, gnt_tmr, data_2, modulo
  );

  modport master (
    output req_fib, data_fib, req_tmr, data_tmr,
    input  gnt_fib, gnt_tmr, data_2, modulo
  );
endinterface

// File: rtl/disp_arb.sv
// Display arbiter between the Fibonacci and Timer modules.
// Once granted, an owner keeps the display for at least HOLD_CONT cycles.
// When both request from idle, the one not served most recently wins.
// The displayed value is registered and follows the owner's data while its
// request is high, otherwise it freezes.
// Ports:
//   clk  : system clock, all state updates on the rising edge
//   rst  : synchronous, active-high reset
//   bus  : disp_arb_if.slave (req_fib/data_fib, req_tmr/data_tmr in;
//          gnt_fib, gnt_tmr, data_2, modulo out)
module disp_arb #(
  parameter int HOLD_CONT = 50,
  parameter int DATA_W    = 16
) (
  input  logic       clk,
  input  logic       rst,
  disp_arb_if.slave  bus
);

  localparam int CNT_W = (HOLD_CONT > 1) ? $clog2(HOLD_CONT) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CONT - 1);

  // State encoding doubles as the owner code driven on modulo.
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    SHOW_FIB = 2'b01,
    SHOW_TMR = 2'b10
  } state_e;

  typedef enum logic {
    OWN_FIB = 1'b0,
    OWN_TMR = 1'b1
  } owner_e;

  state_e            state_q, state_d;
  owner_e            last_q, last_d;
  logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              hold_done;
  logic              enter;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == HOLD_LAST) ? v : v + 1'b1;
  endfunction

  assign hold_done = (hold_cnt_q == HOLD_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req_fib && bus.req_tmr)
          state_d = (last_q == OWN_TMR) ? SHOW_FIB : SHOW_TMR;
        else if (bus.req_fib)
          state_d = SHOW_FIB;
        else if (bus.req_tmr)
          state_d = SHOW_TMR;
      end
      SHOW_FIB: begin
        // Only a finished hold may release or hand over the display.
        if (hold_done) begin
          if (bus.req_tmr)
            state_d = SHOW_TMR;
          else if (!bus.req_fib)
            state_d = IDLE;
        end
      end
      SHOW_TMR: begin
        if (hold_done) begin
          if (bus.req_fib)
            state_d = SHOW_FIB;
          else if (!bus.req_tmr)
            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A SHOW state is entered from IDLE or from the other SHOW state.
  assign enter = (state_d != IDLE) && (state_d != state_q);

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    last_d     = last_q;
    data_d     = data_q;

    if (enter)
      hold_cnt_d = '0;
    else if (state_q != IDLE)
      hold_cnt_d = sat_inc(hold_cnt_q);

    if (enter)
      last_d = (state_d == SHOW_FIB) ? OWN_FIB : OWN_TMR;

    // Load selection uses the next state so a new owner's data appears
    // together with its grant.
    if (state_d == SHOW_FIB && bus.req_fib)
      data_d = bus.data_fib;
    else if (state_d == SHOW_TMR && bus.req_tmr)
      data_d = bus.data_tmr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= OWN_TMR;
      hold_cnt_q <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      data_q     <= data_d;
    end
  end

  assign bus.gnt_fib = (state_q == SHOW_FIB);
  assign bus.gnt_tmr = (state_q == SHOW_TMR);
  assign bus.modulo  = state_q;
  assign bus.data_2  = data_q;

endmodule

// File: tb/tb_disp_arb.sv
// Testbench for disp_arb: directed scenarios on a HOLD_CONT=4 instance and a
// HOLD_CONT=1 instance, followed by a random-request property phase.
module tb_disp_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  disp_arb_if #(.DATA_W(16)) bus4 ();
  disp_arb_if #(.DATA_W(16)) bus1 ();

  disp_arb #(.HOLD_CONT(4), .DATA_W(16)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  disp_arb #(.HOLD_CONT(1), .DATA_W(16)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk4(input string tag, input logic gf, input logic gt,
                      input logic [1:0] m, input logic [15:0] d);
    chk($sformatf("%s.gnt_fib", tag), 32'(bus4.gnt_fib), 32'(gf));
    chk($sformatf("%s.gnt_tmr", tag), 32'(bus4.gnt_tmr), 32'(gt));
    chk($sformatf("%s.modulo", tag),  32'(bus4.modulo),  32'(m));
    chk($sformatf("%s.data_2", tag),  32'(bus4.data_2),  32'(d));
  endtask

  initial begin
    logic       exp_fib;
    logic       pf, pt;
    logic [1:0] prev_mod;
    int         run, wf, wt;

    bus4.req_fib = 1'b0; bus4.data_fib = 16'h0;
    bus4.req_tmr = 1'b0; bus4.data_tmr = 16'h0;
    bus1.req_fib = 1'b0; bus1.data_fib = 16'h0;
    bus1.req_tmr = 1'b0; bus1.data_tmr = 16'h0;

    // Reset state on both instances
    do_reset();
    chk4("rst", 1'b0, 1'b0, 2'b00, 16'h0000);
    chk("rst1.modulo", 32'(bus1.modulo), 32'd0);
    chk("rst1.data_2", 32'(bus1.data_2), 32'd0);

    // Both requesting from reset release: fib 1-4, tmr 5-8, fib 9
    bus4.req_fib = 1'b1; bus4.data_fib = 16'hAAAA;
    bus4.req_tmr = 1'b1; bus4.data_tmr = 16'h5555;
    do_reset();
    for (int c = 1; c <= 9; c++) begin
      tick();
      exp_fib = (c <= 4) || (c == 9);
      chk4($sformatf("rr_c%0d", c), exp_fib, !exp_fib,
           exp_fib ? 2'b01 : 2'b10, exp_fib ? 16'hAAAA : 16'h5555);
    end
    // Release: fib still holds through cycle 12, idle in cycle 13
    bus4.req_fib = 1'b0; bus4.req_tmr = 1'b0;
    for (int c = 10; c <= 13; c++) begin
      tick();
      chk($sformatf("rel_c%0d.modulo", c), 32'(bus4.modulo), (c <= 12) ? 32'd1 : 32'd0);
    end

    // Data follow and freeze on early drop
    do_reset();
    bus4.req_fib = 1'b1; bus4.data_fib = 16'h0001;
    tick();
    chk4("fol_c1", 1'b1, 1'b0, 2'b01, 16'h0001);
    bus4.data_fib = 16'h0002;
    tick();
    chk4("fol_c2", 1'b1, 1'b0, 2'b01, 16'h0002);
    bus4.req_fib = 1'b0; bus4.data_fib = 16'h0003;
    tick();
    chk4("fol_c3", 1'b1, 1'b0, 2'b01, 16'h0002);
    tick();
    chk4("fol_c4", 1'b1, 1'b0, 2'b01, 16'h0002);
    tick();
    chk4("fol_c5", 1'b0, 1'b0, 2'b00, 16'h0002);

    // Timer request arriving mid-hold waits for hold_done
    do_reset();
    bus4.req_fib = 1'b1; bus4.data_fib = 16'h0F0F;
    tick();
    chk4("wait_c1", 1'b1, 1'b0, 2'b01, 16'h0F0F);
    bus4.req_tmr = 1'b1; bus4.data_tmr = 16'h7777;
    for (int c = 2; c <= 5; c++) begin
      tick();
      chk4($sformatf("wait_c%0d", c), c < 5, c == 5, (c < 5) ? 2'b01 : 2'b10,
           (c < 5) ? 16'h0F0F : 16'h7777);
    end
    bus4.req_fib = 1'b0; bus4.req_tmr = 1'b0;

    // Reset mid-grant aborts ownership; round-robin pointer restarts
    do_reset();
    bus4.req_tmr = 1'b1; bus4.data_tmr = 16'h1234;
    tick();
    chk4("abort_pre", 1'b0, 1'b1, 2'b10, 16'h1234);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk4("abort_post", 1'b0, 1'b0, 2'b00, 16'h0000);
    bus4.req_fib = 1'b1; bus4.data_fib = 16'hBEEF;
    tick();
    chk4("abort_rr", 1'b1, 1'b0, 2'b01, 16'hBEEF);
    bus4.req_fib = 1'b0; bus4.req_tmr = 1'b0;

    // HOLD_CONT=1: grant alternates every cycle
    bus1.req_fib = 1'b1; bus1.data_fib = 16'h00F1;
    bus1.req_tmr = 1'b1; bus1.data_tmr = 16'h00E2;
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      tick();
      exp_fib = (c % 2) == 1;
      chk($sformatf("h1_c%0d.gnt_fib", c), 32'(bus1.gnt_fib), 32'(exp_fib));
      chk($sformatf("h1_c%0d.gnt_tmr", c), 32'(bus1.gnt_tmr), 32'(!exp_fib));
      chk($sformatf("h1_c%0d.modulo", c), 32'(bus1.modulo), exp_fib ? 32'd1 : 32'd2);
      chk($sformatf("h1_c%0d.data_2", c), 32'(bus1.data_2), exp_fib ? 32'h00F1 : 32'h00E2);
    end
    bus1.req_fib = 1'b0; bus1.req_tmr = 1'b0;

    // Random requests: minimum hold, legal owner code, bounded wait
    do_reset();
    prev_mod = 2'b00;
    run = 0; wf = 0; wt = 0;
    for (int i = 0; i < 4000; i++) begin
      pf = 1'($urandom_range(0, 1));
      pt = 1'($urandom_range(0, 1));
      bus4.req_fib = pf; bus4.data_fib = 16'($urandom);
      bus4.req_tmr = pt; bus4.data_tmr = 16'($urandom);
      tick();
      chk("rnd.one_gnt", 32'(bus4.gnt_fib & bus4.gnt_tmr), 32'd0);
      chk("rnd.mod_legal", 32'(bus4.modulo == 2'b11), 32'd0);
      if (bus4.modulo != prev_mod) begin
        if (prev_mod != 2'b00)
          chk($sformatf("rnd.hold_len_i%0d", i), 32'(run >= 4), 32'd1);
        run = 1;
        prev_mod = bus4.modulo;
      end else begin
        run++;
      end
      wf = (pf && !bus4.gnt_fib) ? wf + 1 : 0;
      wt = (pt && !bus4.gnt_tmr) ? wt + 1 : 0;
      if (wf > 5 || wt > 5)
        chk($sformatf("rnd.wait_i%0d", i), 32'(wf > wt ? wf : wt), 32'd5);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
